// File: rtl/bp_sched_pkg.sv
// Shared types for the branch-predictor access scheduler: FSM states,
// buffered update entries and the table command word.
package bp_sched_pkg;

    localparam int BP_ADDR_W = 13;
    localparam int BP_SRC_W  = 2;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic [BP_ADDR_W-1:0] addr;
        logic [BP_ADDR_W-1:0] target;
        logic                 taken;
    } upd_entry_t;

    typedef struct packed {
        logic                 write;
        logic [BP_ADDR_W-1:0] addr;
        logic [BP_ADDR_W-1:0] target;
        logic                 taken;
        logic [BP_SRC_W-1:0]  src;
    } tbl_cmd_t;

    // Next round-robin start port after granting idx, wrapping at num ports.
    function automatic logic [1:0] rr_advance(input logic [1:0] idx, input int unsigned num);
        logic [2:0] nxt;
        nxt = {1'b0, idx} + 3'd1;
        return (nxt >= 3'(num)) ? 2'd0 : nxt[1:0];
    endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Synchronous FIFO buffering resolution updates for the access scheduler.
// DEPTH must be a power of two so the pointers wrap naturally.
module bp_upd_fifo
    import bp_sched_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             pon_rst_n_i,
    input  logic             push,
    input  upd_entry_t       push_data,
    input  logic             pop,
    output upd_entry_t       head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    upd_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array; contents need no reset because count guards every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; a simultaneous push and pop keeps count.
    always_ff @(posedge clk or negedge pon_rst_n_i) begin
        if (!pon_rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bp_access_scheduler.sv
// Arbitrates fetch lookups and buffered resolution updates onto the
// single-ported branch prediction table, with a flush/drain sequence.
// Optional feature macro: BP_SCHED_STARVE_EN forces an update once the
// update FIFO has waited STARVE_LIMIT cycles behind lookups.
// ADDR_W must equal bp_sched_pkg::BP_ADDR_W since the command struct uses it.
module bp_access_scheduler
    import bp_sched_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int ADDR_W       = 13,
    parameter int UPD_DEPTH    = 4,
    parameter int UPD_HI_WM    = 3,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                      clk,
    input  logic                      pon_rst_n_i,
    input  logic [NUM_REQ-1:0]        lk_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0] lk_addr_i,
    output logic [NUM_REQ-1:0]        lk_ready_o,
    input  logic                      upd_valid_i,
    input  logic [ADDR_W-1:0]         upd_addr_i,
    input  logic [ADDR_W-1:0]         upd_target_i,
    input  logic                      upd_taken_i,
    output logic                      upd_ready_o,
    input  logic                      flush_i,
    output logic                      flush_done_o,
    output logic                      tbl_valid_o,
    input  logic                      tbl_ready_i,
    output logic                      tbl_write_o,
    output logic [ADDR_W-1:0]         tbl_addr_o,
    output logic [ADDR_W-1:0]         tbl_target_o,
    output logic                      tbl_taken_o,
    output logic [1:0]                tbl_src_o,
    output logic [2:0]                upd_count_o
);

    localparam int CNT_W = $clog2(UPD_DEPTH) + 1;

    sched_state_e     state;
    logic             flush_done_q;
    logic             tbl_valid_q;
    tbl_cmd_t         cmd_q;
    tbl_cmd_t         cmd_d;
    logic [1:0]       rr_ptr;

    upd_entry_t       upd_in;
    upd_entry_t       upd_head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_hi;
    logic             upd_push;

    logic             slot_free;
    logic             any_lk;
    logic [1:0]       lk_idx;
    logic [ADDR_W-1:0] lk_addr_sel;
    logic             sel_upd;
    logic             sel_lk;
    logic             starve_force;

    assign upd_in      = '{addr: upd_addr_i, target: upd_target_i, taken: upd_taken_i};
    assign upd_ready_o = !fifo_full;
    assign upd_push    = upd_valid_i && upd_ready_o;
    assign fifo_hi     = (fifo_count >= CNT_W'(UPD_HI_WM));
    assign slot_free   = !tbl_valid_q || tbl_ready_i;

    bp_upd_fifo #(
        .DEPTH (UPD_DEPTH)
    ) u_upd_fifo (
        .clk         (clk),
        .pon_rst_n_i (pon_rst_n_i),
        .push        (upd_push),
        .push_data   (upd_in),
        .pop         (sel_upd),
        .head        (upd_head),
        .count       (fifo_count),
        .full        (fifo_full),
        .empty       (fifo_empty)
    );

`ifdef BP_SCHED_STARVE_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] starve_cnt;

    // Count cycles a non-empty FIFO waits without an update issuing; saturates.
    always_ff @(posedge clk or negedge pon_rst_n_i) begin
        if (!pon_rst_n_i) begin
            starve_cnt <= '0;
        end else if (fifo_empty || sel_upd) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

    assign starve_force = (starve_cnt == STARVE_W'(STARVE_LIMIT));
`else
    assign starve_force = 1'b0;
`endif

    // Round-robin search for the first requesting port starting at rr_ptr.
    always_comb begin
        logic [1:0] cand;
        any_lk = 1'b0;
        lk_idx = '0;
        cand   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = 2'((int'(rr_ptr) + i) % NUM_REQ);
            for (int p = 0; p < NUM_REQ; p++) begin
                if (!any_lk && lk_valid_i[p] && (cand == 2'(p))) begin
                    any_lk = 1'b1;
                    lk_idx = 2'(p);
                end
            end
        end
    end

    // Pick what fills the slot: watermark/starved updates, lookups, then leftovers.
    always_comb begin
        sel_upd = 1'b0;
        sel_lk  = 1'b0;
        if (slot_free) begin
            if (state == RUN) begin
                if ((fifo_hi || starve_force) && !fifo_empty) begin
                    sel_upd = 1'b1;
                end else if (any_lk) begin
                    sel_lk = 1'b1;
                end else if (!fifo_empty) begin
                    sel_upd = 1'b1;
                end
            end else begin
                sel_upd = !fifo_empty;
            end
        end
    end

    // One-hot lookup grant for the port selected this cycle.
    always_comb begin
        lk_ready_o  = '0;
        lk_addr_sel = '0;
        for (int p = 0; p < NUM_REQ; p++) begin
            lk_ready_o[p] = sel_lk && (lk_idx == 2'(p));
            if (lk_idx == 2'(p)) begin
                lk_addr_sel = lk_addr_i[p*ADDR_W +: ADDR_W];
            end
        end
    end

    // Build the next table command; unused fields stay zero.
    always_comb begin
        cmd_d = '0;
        if (sel_upd) begin
            cmd_d.write  = 1'b1;
            cmd_d.addr   = upd_head.addr;
            cmd_d.target = upd_head.target;
            cmd_d.taken  = upd_head.taken;
        end else if (sel_lk) begin
            cmd_d.addr = lk_addr_sel;
            cmd_d.src  = lk_idx;
        end
    end

    // Output slot register and round-robin pointer; both hold while stalled.
    always_ff @(posedge clk or negedge pon_rst_n_i) begin
        if (!pon_rst_n_i) begin
            tbl_valid_q <= 1'b0;
            cmd_q       <= '0;
            rr_ptr      <= '0;
        end else if (slot_free) begin
            tbl_valid_q <= sel_upd || sel_lk;
            cmd_q       <= cmd_d;
            if (sel_lk) begin
                rr_ptr <= rr_advance(lk_idx, NUM_REQ);
            end
        end
    end

    // Flush sequencing; drain finishes only once the FIFO and slot are empty.
    always_ff @(posedge clk or negedge pon_rst_n_i) begin
        if (!pon_rst_n_i) begin
            state        <= RUN;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            case (state)
                RUN: begin
                    if (flush_i) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty && slot_free && !upd_push) begin
                        state        <= DONE;
                        flush_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    assign tbl_valid_o  = tbl_valid_q;
    assign tbl_write_o  = cmd_q.write;
    assign tbl_addr_o   = cmd_q.addr;
    assign tbl_target_o = cmd_q.target;
    assign tbl_taken_o  = cmd_q.taken;
    assign tbl_src_o    = cmd_q.src;
    assign flush_done_o = flush_done_q;
    assign upd_count_o  = 3'(fifo_count);

endmodule

// File: tb/tb_bp_access_scheduler.sv
// Self-checking bench for bp_access_scheduler: a lookup vector table plus
// hand-written watermark, full/backpressure, flush and reset-mid-drain runs.
// Issued table commands are checked against a scoreboard queue.
module tb_bp_access_scheduler;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 13;

    logic                      clk = 1'b0;
    logic                      pon_rst_n_i;
    logic [NUM_REQ-1:0]        lk_valid_i;
    logic [NUM_REQ*ADDR_W-1:0] lk_addr_i;
    logic [NUM_REQ-1:0]        lk_ready_o;
    logic                      upd_valid_i;
    logic [ADDR_W-1:0]         upd_addr_i;
    logic [ADDR_W-1:0]         upd_target_i;
    logic                      upd_taken_i;
    logic                      upd_ready_o;
    logic                      flush_i;
    logic                      flush_done_o;
    logic                      tbl_valid_o;
    logic                      tbl_ready_i;
    logic                      tbl_write_o;
    logic [ADDR_W-1:0]         tbl_addr_o;
    logic [ADDR_W-1:0]         tbl_target_o;
    logic                      tbl_taken_o;
    logic [1:0]                tbl_src_o;
    logic [2:0]                upd_count_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] sb_q [$];

    typedef struct {
        logic [1:0]  lv;
        logic [12:0] a0;
        logic [12:0] a1;
        logic        tr;
        logic [1:0]  exp_rdy;
        logic        exp_valid;
    } vec_t;

    vec_t vecs [12];

    bp_access_scheduler #(
        .NUM_REQ      (NUM_REQ),
        .ADDR_W       (ADDR_W),
        .UPD_DEPTH    (4),
        .UPD_HI_WM    (3),
        .STARVE_LIMIT (8)
    ) dut (
        .clk          (clk),
        .pon_rst_n_i  (pon_rst_n_i),
        .lk_valid_i   (lk_valid_i),
        .lk_addr_i    (lk_addr_i),
        .lk_ready_o   (lk_ready_o),
        .upd_valid_i  (upd_valid_i),
        .upd_addr_i   (upd_addr_i),
        .upd_target_i (upd_target_i),
        .upd_taken_i  (upd_taken_i),
        .upd_ready_o  (upd_ready_o),
        .flush_i      (flush_i),
        .flush_done_o (flush_done_o),
        .tbl_valid_o  (tbl_valid_o),
        .tbl_ready_i  (tbl_ready_i),
        .tbl_write_o  (tbl_write_o),
        .tbl_addr_o   (tbl_addr_o),
        .tbl_target_o (tbl_target_o),
        .tbl_taken_o  (tbl_taken_o),
        .tbl_src_o    (tbl_src_o),
        .upd_count_o  (upd_count_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] packCmd(input logic w, input logic [12:0] a,
                                            input logic [12:0] t, input logic tk,
                                            input logic [1:0] s);
        return {2'b00, w, a, t, tk, s};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic expectCmd(input logic w, input logic [12:0] a, input logic [12:0] t,
                             input logic tk, input logic [1:0] s);
        sb_q.push_back(packCmd(w, a, t, tk, s));
    endtask

    task automatic checkScoreboard();
        logic [31:0] exp_cmd;
        if (tbl_valid_o && tbl_ready_i) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL sb_unexpected: got cmd 0x%0h, expected none",
                         packCmd(tbl_write_o, tbl_addr_o, tbl_target_o, tbl_taken_o, tbl_src_o));
            end else begin
                exp_cmd = sb_q.pop_front();
                checkOutput("sb_cmd",
                            packCmd(tbl_write_o, tbl_addr_o, tbl_target_o, tbl_taken_o, tbl_src_o),
                            exp_cmd);
            end
        end
    endtask

    task automatic applyStimulus(input logic [1:0] lv, input logic [12:0] a0, input logic [12:0] a1,
                                 input logic uv, input logic [12:0] ua, input logic [12:0] ut,
                                 input logic utk, input logic tr, input logic fl);
        @(negedge clk);
        lk_valid_i   = lv;
        lk_addr_i    = {a1, a0};
        upd_valid_i  = uv;
        upd_addr_i   = ua;
        upd_target_i = ut;
        upd_taken_i  = utk;
        tbl_ready_i  = tr;
        flush_i      = fl;
        #1;
        checkScoreboard();
    endtask

    task automatic doReset();
        @(negedge clk);
        pon_rst_n_i  = 1'b0;
        lk_valid_i   = '0;
        lk_addr_i    = '0;
        upd_valid_i  = 1'b0;
        upd_addr_i   = '0;
        upd_target_i = '0;
        upd_taken_i  = 1'b0;
        tbl_ready_i  = 1'b0;
        flush_i      = 1'b0;
        sb_q.delete();
        repeat (2) @(negedge clk);
        pon_rst_n_i = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{lv: 2'b00, a0: 13'h000,  a1: 13'h000,  tr: 1'b1, exp_rdy: 2'b00, exp_valid: 1'b0};
        vecs[1]  = '{lv: 2'b10, a0: 13'h000,  a1: 13'h0A5,  tr: 1'b1, exp_rdy: 2'b10, exp_valid: 1'b0};
        vecs[2]  = '{lv: 2'b11, a0: 13'h011,  a1: 13'h022,  tr: 1'b1, exp_rdy: 2'b01, exp_valid: 1'b1};
        vecs[3]  = '{lv: 2'b11, a0: 13'h012,  a1: 13'h023,  tr: 1'b1, exp_rdy: 2'b10, exp_valid: 1'b1};
        vecs[4]  = '{lv: 2'b11, a0: 13'h013,  a1: 13'h024,  tr: 1'b1, exp_rdy: 2'b01, exp_valid: 1'b1};
        vecs[5]  = '{lv: 2'b11, a0: 13'h014,  a1: 13'h025,  tr: 1'b1, exp_rdy: 2'b10, exp_valid: 1'b1};
        vecs[6]  = '{lv: 2'b01, a0: 13'h1FFF, a1: 13'h000,  tr: 1'b1, exp_rdy: 2'b01, exp_valid: 1'b1};
        vecs[7]  = '{lv: 2'b01, a0: 13'h0AAA, a1: 13'h000,  tr: 1'b1, exp_rdy: 2'b01, exp_valid: 1'b1};
        vecs[8]  = '{lv: 2'b10, a0: 13'h000,  a1: 13'h1555, tr: 1'b1, exp_rdy: 2'b10, exp_valid: 1'b1};
        vecs[9]  = '{lv: 2'b11, a0: 13'h031,  a1: 13'h032,  tr: 1'b0, exp_rdy: 2'b00, exp_valid: 1'b1};
        vecs[10] = '{lv: 2'b11, a0: 13'h031,  a1: 13'h032,  tr: 1'b1, exp_rdy: 2'b01, exp_valid: 1'b1};
        vecs[11] = '{lv: 2'b00, a0: 13'h000,  a1: 13'h000,  tr: 1'b1, exp_rdy: 2'b00, exp_valid: 1'b1};

        // ---------------- reset values ----------------
        doReset();
        pon_rst_n_i = 1'b0;
        #1;
        checkOutput("rst_tbl_valid", tbl_valid_o, 0);
        checkOutput("rst_upd_ready", upd_ready_o, 1);
        checkOutput("rst_upd_count", upd_count_o, 0);
        checkOutput("rst_flush_done", flush_done_o, 0);
        checkOutput("rst_lk_ready", lk_ready_o, 0);
        checkOutput("rst_tbl_fields",
                    packCmd(tbl_write_o, tbl_addr_o, tbl_target_o, tbl_taken_o, tbl_src_o), 0);
        @(negedge clk);
        pon_rst_n_i = 1'b1;

        // ---------------- lookup vector table ----------------
        for (int k = 0; k < 12; k++) begin
            applyStimulus(vecs[k].lv, vecs[k].a0, vecs[k].a1, 1'b0, '0, '0, 1'b0,
                          vecs[k].tr, 1'b0);
            checkOutput($sformatf("vec%0d_lk_ready", k), lk_ready_o, vecs[k].exp_rdy);
            checkOutput($sformatf("vec%0d_tbl_valid", k), tbl_valid_o, vecs[k].exp_valid);
            if (vecs[k].exp_rdy[0]) begin
                expectCmd(1'b0, vecs[k].a0, '0, 1'b0, 2'd0);
            end else if (vecs[k].exp_rdy[1]) begin
                expectCmd(1'b0, vecs[k].a1, '0, 1'b0, 2'd1);
            end
        end
        applyStimulus(2'b00, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("vec_tail_tbl_valid", tbl_valid_o, 0);
        checkOutput("vec_sb_empty", sb_q.size(), 0);

        // ---------------- watermark and FIFO full under backpressure ----------------
        doReset();
        applyStimulus(2'b00, '0, '0, 1'b1, 13'h200, 13'h100, 1'b1, 1'b0, 1'b0);
        checkOutput("wm_c1_upd_ready", upd_ready_o, 1);
        checkOutput("wm_c1_tbl_valid", tbl_valid_o, 0);
        applyStimulus(2'b00, '0, '0, 1'b1, 13'h201, 13'h101, 1'b0, 1'b0, 1'b0);
        expectCmd(1'b1, 13'h200, 13'h100, 1'b1, 2'd0);
        checkOutput("wm_c2_tbl_valid", tbl_valid_o, 0);
        applyStimulus(2'b00, '0, '0, 1'b1, 13'h202, 13'h102, 1'b1, 1'b0, 1'b0);
        checkOutput("wm_c3_tbl_valid", tbl_valid_o, 1);
        checkOutput("wm_c3_target", tbl_target_o, 13'h100);
        checkOutput("wm_c3_count", upd_count_o, 1);
        applyStimulus(2'b00, '0, '0, 1'b1, 13'h203, 13'h103, 1'b0, 1'b0, 1'b0);
        checkOutput("wm_c4_count", upd_count_o, 2);
        checkOutput("wm_c4_target", tbl_target_o, 13'h100);
        applyStimulus(2'b00, '0, '0, 1'b1, 13'h204, 13'h104, 1'b1, 1'b0, 1'b0);
        checkOutput("wm_c5_count", upd_count_o, 3);
        checkOutput("wm_c5_upd_ready", upd_ready_o, 1);
        applyStimulus(2'b00, '0, '0, 1'b1, 13'h2FF, 13'h1FF, 1'b1, 1'b0, 1'b0);
        checkOutput("full_count", upd_count_o, 4);
        checkOutput("full_upd_ready", upd_ready_o, 0);
        checkOutput("full_hold_cmd",
                    packCmd(tbl_write_o, tbl_addr_o, tbl_target_o, tbl_taken_o, tbl_src_o),
                    packCmd(1'b1, 13'h200, 13'h100, 1'b1, 2'd0));
        applyStimulus(2'b11, 13'h050, 13'h060, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("wm_c7_lk_ready", lk_ready_o, 2'b00);
        checkOutput("wm_c7_upd_ready", upd_ready_o, 0);
        expectCmd(1'b1, 13'h201, 13'h101, 1'b0, 2'd0);
        applyStimulus(2'b11, 13'h050, 13'h060, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("wm_c8_count", upd_count_o, 3);
        checkOutput("wm_c8_lk_ready", lk_ready_o, 2'b00);
        expectCmd(1'b1, 13'h202, 13'h102, 1'b1, 2'd0);
        applyStimulus(2'b11, 13'h050, 13'h060, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("wm_c9_lk_ready", lk_ready_o, 2'b01);
        expectCmd(1'b0, 13'h050, '0, 1'b0, 2'd0);
        applyStimulus(2'b11, 13'h050, 13'h060, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("wm_c10_lk_ready", lk_ready_o, 2'b10);
        expectCmd(1'b0, 13'h060, '0, 1'b0, 2'd1);
        applyStimulus(2'b00, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("wm_c11_count", upd_count_o, 2);
        expectCmd(1'b1, 13'h203, 13'h103, 1'b0, 2'd0);
        applyStimulus(2'b00, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("wm_c12_count", upd_count_o, 1);
        expectCmd(1'b1, 13'h204, 13'h104, 1'b1, 2'd0);
        applyStimulus(2'b00, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("wm_c13_count", upd_count_o, 0);
        applyStimulus(2'b00, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("wm_tail_tbl_valid", tbl_valid_o, 0);
        checkOutput("wm_tail_upd_ready", upd_ready_o, 1);
        checkOutput("wm_sb_empty", sb_q.size(), 0);

        // ---------------- flush / drain ----------------
        doReset();
        applyStimulus(2'b01, 13'h040, '0, 1'b1, 13'h300, 13'h0AA, 1'b1, 1'b1, 1'b0);
        checkOutput("fl_c1_lk_ready", lk_ready_o, 2'b01);
        expectCmd(1'b0, 13'h040, '0, 1'b0, 2'd0);
        applyStimulus(2'b01, 13'h041, '0, 1'b1, 13'h301, 13'h0AB, 1'b0, 1'b1, 1'b1);
        checkOutput("fl_c2_lk_ready", lk_ready_o, 2'b01);
        expectCmd(1'b0, 13'h041, '0, 1'b0, 2'd0);
        applyStimulus(2'b01, 13'h042, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("fl_c3_lk_ready", lk_ready_o, 2'b00);
        checkOutput("fl_c3_count", upd_count_o, 2);
        expectCmd(1'b1, 13'h300, 13'h0AA, 1'b1, 2'd0);
        applyStimulus(2'b01, 13'h042, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        checkOutput("fl_c4_lk_ready", lk_ready_o, 2'b00);
        expectCmd(1'b1, 13'h301, 13'h0AB, 1'b0, 2'd0);
        applyStimulus(2'b01, 13'h042, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("fl_c5_lk_ready", lk_ready_o, 2'b00);
        checkOutput("fl_c5_flush_done", flush_done_o, 0);
        applyStimulus(2'b01, 13'h042, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("fl_c6_flush_done", flush_done_o, 1);
        checkOutput("fl_c6_lk_ready", lk_ready_o, 2'b00);
        checkOutput("fl_c6_tbl_valid", tbl_valid_o, 0);
        applyStimulus(2'b01, 13'h042, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("fl_c7_lk_ready", lk_ready_o, 2'b01);
        checkOutput("fl_c7_flush_done", flush_done_o, 0);
        expectCmd(1'b0, 13'h042, '0, 1'b0, 2'd0);
        applyStimulus(2'b00, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("fl_c8_flush_done", flush_done_o, 0);
        applyStimulus(2'b00, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("fl_sb_empty", sb_q.size(), 0);

        // ---------------- reset in the middle of a drain ----------------
        doReset();
        applyStimulus(2'b00, '0, '0, 1'b1, 13'h310, 13'h0C0, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b00, '0, '0, 1'b1, 13'h311, 13'h0C1, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b00, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("rd_c3_tbl_valid", tbl_valid_o, 1);
        checkOutput("rd_c3_count", upd_count_o, 1);
        applyStimulus(2'b01, 13'h070, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("rd_c4_lk_ready", lk_ready_o, 2'b00);
        #2;
        pon_rst_n_i = 1'b0;
        lk_valid_i  = '0;
        #1;
        checkOutput("rd_rst_tbl_valid", tbl_valid_o, 0);
        checkOutput("rd_rst_count", upd_count_o, 0);
        checkOutput("rd_rst_upd_ready", upd_ready_o, 1);
        checkOutput("rd_rst_flush_done", flush_done_o, 0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        pon_rst_n_i = 1'b1;
        applyStimulus(2'b00, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("rd_r1_flush_done", flush_done_o, 0);
        checkOutput("rd_r1_tbl_valid", tbl_valid_o, 0);
        applyStimulus(2'b01, 13'h07F, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("rd_r2_lk_ready", lk_ready_o, 2'b01);
        checkOutput("rd_r2_flush_done", flush_done_o, 0);
        expectCmd(1'b0, 13'h07F, '0, 1'b0, 2'd0);
        applyStimulus(2'b00, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("rd_r3_flush_done", flush_done_o, 0);
        applyStimulus(2'b00, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("rd_r4_flush_done", flush_done_o, 0);
        checkOutput("rd_sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bp_access_scheduler.md
# bp_access_scheduler

Sequences all accesses to the branch predictor's single-ported prediction table (BTB plus 2-bit counters). It arbitrates between NUM_REQ fetch lookup ports and one buffered resolution-update stream, and issues one table command per accepted slot over a valid/ready interface. It also implements a flush/drain sequence so that pending updates are committed before lookups resume. It sits between the fetch/resolve stages and the predictor table.

## Interface
Parameters:
- NUM_REQ, 2, number of lookup requesters (2..4)
- ADDR_W, 13, branch/target address width
- UPD_DEPTH, 4, update FIFO depth (power of 2)
- UPD_HI_WM, 3, FIFO occupancy at or above which updates take priority
- STARVE_LIMIT, 8, cycles a non-empty FIFO may wait before a forced update (used only with the macro)

Ports:
- clk  in  1  clock
- pon_rst_n_i  in  1  reset, asynchronous, active-low
- lk_valid_i  in  NUM_REQ  lookup request per port
- lk_addr_i  in  NUM_REQ*ADDR_W  lookup branch address, port i at [i*ADDR_W +: ADDR_W]
- lk_ready_o  out  NUM_REQ  one-hot grant; the lookup is accepted when valid and ready are both high
- upd_valid_i  in  1  resolution update request
- upd_addr_i  in  ADDR_W  resolved branch address
- upd_target_i  in  ADDR_W  resolved target
- upd_taken_i  in  1  actual direction
- upd_ready_o  out  1  FIFO not full
- flush_i  in  1  single-cycle pulse that requests a drain
- flush_done_o  out  1  one-cycle pulse when the drain completes
- tbl_valid_o  out  1  command valid
- tbl_ready_i  in  1  table accepts the command
- tbl_write_o  out  1  1 = update, 0 = lookup
- tbl_addr_o  out  ADDR_W  table address
- tbl_target_o  out  ADDR_W  update target (0 for lookups)
- tbl_taken_o  out  1  update direction (0 for lookups)
- tbl_src_o  out  2  granted lookup port; 0 for updates
- upd_count_o  out  3  FIFO occupancy

## Operation
- **Update FIFO:** a push occurs when upd_valid_i && upd_ready_o. upd_ready_o = (count != UPD_DEPTH); it is registered-count based, so it stays low while full even if a pop happens in the same cycle. A push and a pop in the same cycle leave the count unchanged.
- **Issue slot:** there is a single output register. A new selection is made only when the slot is free, i.e. !tbl_valid_o || tbl_ready_i. While tbl_valid_o=1 && !tbl_ready_i, all tbl_* outputs hold stable and lk_ready_o = 0.
- **Selection priority (state RUN):**
  1. FIFO count >= UPD_HI_WM → update.
  2. Otherwise, any lk_valid_i → round-robin, starting at the port after the last granted port.
  3. Otherwise, FIFO non-empty → update.
  4. Otherwise the slot empties.
- **Lookup grant:** lk_ready_o[g] is driven combinationally in the selection cycle. The round-robin pointer advances only when a lookup is granted.
- **States:**
  - RUN: normal arbitration. flush_i → DRAIN.
  - DRAIN: lk_ready_o = 0 and only updates are issued. When the FIFO is empty and the slot is free → DONE.
  - DONE: flush_done_o = 1 for one cycle, then → RUN.
- flush_i received outside RUN is ignored. Updates are still accepted in DRAIN. The drain completes only once pushes stop and the FIFO empties.
- **Reset mid-operation:** FIFO contents are discarded, the pending command is dropped, and the state returns to RUN.

## Timing
- **Reset values:** all outputs 0, except upd_ready_o = 1. State = RUN, round-robin pointer = 0, FIFO empty.
- **Lookup latency:** a lookup accepted at edge N produces tbl_valid_o at N+1, provided tbl_ready_i was high.
- **Update latency:** an update pushed at edge N is eligible at N+1 and appears on tbl_* at N+2 at the earliest.
- **Throughput:** one command per cycle when tbl_ready_i stays high.
- flush_done_o asserts one cycle after the final update's handshake completes.

## Configuration
- **BP_SCHED_STARVE_EN defined:** a starvation counter increments each cycle that the FIFO is non-empty and no update issues; it clears on any update issue or when the FIFO is empty. When the counter reaches STARVE_LIMIT, the next free slot issues an update regardless of lookups.
- **BP_SCHED_STARVE_EN undefined:** no counter is built and the priority is exactly as listed in Operation.

## Structure
- **Package bp_sched_pkg:**
  - state enum {RUN, DRAIN, DONE}
  - update-entry struct {addr, target, taken}
  - command struct matching the tbl_* fields
- **Sub-module bp_upd_fifo:** the parameterized synchronous FIFO (push, pop, count, head). The arbiter and FSM stay in the top module.

## Test plan
- **Single lookup:** port 1 requests addr 0x0A5 with tbl_ready_i=1 → lk_ready_o = 2'b10 in that cycle; next cycle tbl_valid_o=1, tbl_write_o=0, tbl_addr_o=0x0A5, tbl_src_o=1.
- **Fairness:** ports 0 and 1 request continuously → grants alternate 0,1,0,1 over 4 cycles.
- **Watermark:** push 3 updates (targets 0x100, 0x101, 0x102) with tbl_ready_i=0, then release with both ports requesting → the first command is the update with target 0x100, issued in FIFO order until the count drops below 3.
- **Backpressure/full:** hold tbl_ready_i=0 and push 4 updates → upd_ready_o=0 after the 4th push; the tbl_* outputs stay stable; upd_count_o=4.
- **Flush:** 2 updates queued, flush_i pulsed → no lk_ready_o during the drain; 2 update commands issue; flush_done_o pulses once; lookups resume the next cycle.
- **Reset mid-drain:** assert pon_rst_n_i=0 during DRAIN → tbl_valid_o=0, upd_count_o=0, upd_ready_o=1 immediately, and no flush_done_o pulse.
